if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC and runs a request/ready handshake to instruction memory, which may take a variable number of wait states.
- Drives the IF/ID pipeline register (Instruction, PC, PC+4, Valid) that the decoder consumes.
- Honours Stall from hazard detection and Redirect (taken branch / JAL / JALR resolved in EX).

---
 rtl/if_stage.sv | 206 ++++++++++++++++++++
 tb/tb_if_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC, runs the request/ready handshake to instruction memory and
// drives the IF/ID pipeline register consumed by decode.
// Optional build macro IF_PREDECODE_JAL_EN enables JAL predecode: a fetched
// JAL redirects the next fetch immediately and sets IF_ID_PredTaken.
//
// Memory handshake: imem_req is the valid, imem_ready is the ready. A
// transfer happens on any cycle where imem_req=1 and imem_ready=1; imem_rdata
// is only meaningful on that cycle. Once imem_req is raised, imem_addr stays
// stable until the transfer, even across a redirect (S_DRAIN finishes the
// old request before the new target is fetched).
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PCplus4,
    output logic        IF_ID_Valid,
    output logic        IF_ID_PredTaken,
    output logic        FetchBusy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;

    logic        ifid_load;      // load a real instruction into IF/ID
    logic        ifid_bubble;    // load a bubble into IF/ID
    logic [31:0] xfer_instr;     // instruction entering IF/ID this cycle
    logic [31:0] next_pc;        // PC following xfer_instr
    logic        pred_taken;     // xfer_instr redirects fetch by itself
    logic [31:0] redirect_target;

    // Low two bits of the redirect target are ignored.
    assign redirect_target = RedirectPC & WORD_MASK;

    // The instruction handed to decode comes from memory in S_REQ and from
    // the hold buffer when a stalled capture is released.
    assign xfer_instr = (state_q == S_HOLD) ? hold_buf_q : imem_rdata;

`ifdef IF_PREDECODE_JAL_EN
    logic [31:0] jal_imm;

    // Predecode JAL: next fetch goes to PC + J-immediate.
    always_comb begin
        jal_imm    = {{11{xfer_instr[31]}}, xfer_instr[31], xfer_instr[19:12],
                      xfer_instr[20], xfer_instr[30:21], 1'b0};
        pred_taken = (xfer_instr[6:0] == 7'b1101111);
        if (pred_taken) begin
            next_pc = (pc_q + jal_imm) & WORD_MASK;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end
`else
    // Sequential fetch only; nothing is ever predicted taken.
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_q + 32'd4;
    end
`endif

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, memory interface and IF/ID load decisions.
    // Priority: Redirect > Stall > normal advance (reset handled in the flops).
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_buf_d   = hold_buf_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = pc_q;

        case (state_q)
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (Redirect) begin
                    // Any data returned now belongs to the wrong path.
                    pc_d        = redirect_target;
                    ifid_bubble = 1'b1;
                    if (!imem_ready) begin
                        // Request still outstanding: finish it at the old address.
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (imem_ready && !Stall) begin
                    ifid_load = 1'b1;
                    pc_d      = next_pc;
                end else if (imem_ready) begin
                    // Memory delivered but decode is frozen: park the word.
                    hold_buf_d = imem_rdata;
                    state_d    = S_HOLD;
                end else if (!Stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            S_HOLD: begin
                if (Redirect) begin
                    pc_d        = redirect_target;
                    ifid_bubble = 1'b1;
                    state_d     = S_REQ;
                end else if (!Stall) begin
                    ifid_load = 1'b1;
                    pc_d      = next_pc;
                    state_d   = S_REQ;
                end
            end

            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (Redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_ready) begin
                    state_d = S_REQ;
                end
                if (Redirect || !Stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        // No request may be presented while reset is asserted.
        if (reset) begin
            imem_req = 1'b0;
        end
    end

    // PC, drain address and hold buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC & WORD_MASK;
            drain_addr_q <= 32'd0;
            hold_buf_q   <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_buf_q   <= hold_buf_d;
        end
    end

    // IF/ID pipeline register: real instruction, bubble, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PC          <= 32'd0;
            IF_ID_PCplus4     <= 32'd0;
            IF_ID_Valid       <= 1'b0;
            IF_ID_PredTaken   <= 1'b0;
        end else if (ifid_load) begin
            IF_ID_Instruction <= xfer_instr;
            IF_ID_PC          <= pc_q;
            IF_ID_PCplus4     <= pc_q + 32'd4;
            IF_ID_Valid       <= 1'b1;
            IF_ID_PredTaken   <= pred_taken;
        end else if (ifid_bubble) begin
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PC          <= 32'd0;
            IF_ID_PCplus4     <= 32'd0;
            IF_ID_Valid       <= 1'b0;
            IF_ID_PredTaken   <= 1'b0;
        end
    end

    // Busy while a request is presented and memory is inserting wait states.
    assign FetchBusy = imem_req && !imem_ready;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model of the fetch rules.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PCplus4;
    logic        IF_ID_Valid;
    logic        IF_ID_PredTaken;
    logic        FetchBusy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PC         (IF_ID_PC),
        .IF_ID_PCplus4    (IF_ID_PCplus4),
        .IF_ID_Valid      (IF_ID_Valid),
        .IF_ID_PredTaken  (IF_ID_PredTaken),
        .FetchBusy        (FetchBusy),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory contents ----------------
    // 0x30 holds jal x0,+0x100 (imm[8] lives in inst[28]). Other words are a
    // hash of the address; words at addr[6:2]==0x1D are also JALs so the
    // random phase exercises predecode when it is built in.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0000_0030) return 32'h1000_006F;
        w = (a * 32'h9E37_79B1) ^ 32'h1357_2468;
        if (a[6:2] == 5'h1D) w[6:0] = 7'b1101111;
        else                 w[6:0] = 7'b0110011;
        return w;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_hold_q[$];    // word captured while decode is stalled
    logic [31:0] m_drain_q[$];   // address of an abandoned, still-open request
    logic [31:0] m_instr, m_pcf, m_pcp4;
    logic        m_valid, m_pred;
    bit          m_delivered;
    logic [31:0] exp_q[$];       // scoreboard of instructions handed to decode

    function automatic logic [31:0] j_imm(input logic [31:0] w);
        logic signed [20:0] imm;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return 32'(imm);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_hold_q.delete(); m_drain_q.delete();
        m_instr = 32'h13; m_pcf = 0; m_pcp4 = 0; m_valid = 0; m_pred = 0;
        exp_q.delete();
    endtask

    task automatic model_bubble();
        m_instr = 32'h13; m_pcf = 0; m_pcp4 = 0; m_valid = 0; m_pred = 0;
    endtask

    task automatic model_deliver(input logic [31:0] w);
        m_instr = w; m_pcf = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1; m_pred = 0;
        exp_q.push_back(w);
        m_delivered = 1;
`ifdef IF_PREDECODE_JAL_EN
        if (w[6:0] == 7'b1101111) begin
            m_pred = 1;
            m_pc   = (m_pc + j_imm(w)) & 32'hFFFF_FFFC;
        end else begin
            m_pc = m_pc + 32'd4;
        end
`else
        m_pc = m_pc + 32'd4;
`endif
    endtask

    task automatic model_update(input bit rst, st, rd, input logic [31:0] rpc, input bit rdy);
        logic [31:0] target;
        m_delivered = 0;
        target = rpc & 32'hFFFF_FFFC;
        if (rst) begin
            model_reset();
        end else if (m_drain_q.size() != 0) begin
            if (rdy) m_drain_q.delete();
            if (rd) m_pc = target;
            if (rd || !st) model_bubble();
        end else if (m_hold_q.size() != 0) begin
            if (rd) begin
                m_hold_q.delete(); m_pc = target; model_bubble();
            end else if (!st) begin
                model_deliver(m_hold_q.pop_front());
            end
        end else begin
            if (rd) begin
                if (!rdy) m_drain_q.push_back(m_pc);
                m_pc = target;
                model_bubble();
            end else if (rdy && !st) begin
                model_deliver(mem_word(m_pc));
            end else if (rdy) begin
                m_hold_q.push_back(mem_word(m_pc));
            end else if (!st) begin
                model_bubble();
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive inputs at negedge, check request side, clock, then
    // check the IF/ID register against the model.
    task automatic step(input bit rst, st, rd, input logic [31:0] rpc, input bit rdy);
        bit exp_req;
        @(negedge clk);
        reset = rst; Stall = st; Redirect = rd; RedirectPC = rpc; imem_ready = rdy;
        #1;
        if (rst) begin
            check("req_in_reset", imem_req, 0);
        end else begin
            exp_req = (m_hold_q.size() == 0);
            check("imem_req", imem_req, exp_req);
            if (exp_req)
                check("imem_addr", imem_addr, (m_drain_q.size() != 0) ? m_drain_q[0] : m_pc);
            check("fetch_busy", FetchBusy, exp_req && !rdy);
        end
        @(posedge clk);
        model_update(rst, st, rd, rpc, rdy);
        #1;
        check("ifid_instr", IF_ID_Instruction, m_instr);
        check("ifid_pc", IF_ID_PC, m_pcf);
        check("ifid_pcp4", IF_ID_PCplus4, m_pcp4);
        check("ifid_valid", IF_ID_Valid, m_valid);
        check("ifid_pred", IF_ID_PredTaken, m_pred);
        if (m_delivered) check("sb_instr", IF_ID_Instruction, exp_q.pop_front());
    endtask

    task automatic goto_pc(input logic [31:0] a);
        step(0, 0, 1, a, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; Stall = 0; Redirect = 0; RedirectPC = 0; imem_ready = 0;
        model_reset();

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check("rst_valid", IF_ID_Valid, 0);
        check("rst_instr", IF_ID_Instruction, 32'h13);
        check("rst_pc", IF_ID_PC, 0);
        check("rst_pred", IF_ID_PredTaken, 0);
        check("rst_fetch_addr", imem_addr, 32'h0);

        // Zero-wait sequential fetch: 0,4,8,C back to back
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            check("seq_pc", IF_ID_PC, 32'(i * 4));
            check("seq_valid", IF_ID_Valid, 1);
        end

        // Two wait states at 0x10
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0);
            check("wait_valid", IF_ID_Valid, 0);
            check("wait_instr", IF_ID_Instruction, 32'h13);
            check("wait_addr", imem_addr, 32'h10);
        end
        step(0, 0, 0, 0, 1);
        check("wait_done_pc", IF_ID_PC, 32'h10);
        check("wait_next_addr", imem_addr, 32'h14);

        // Stall capture at 0x20
        goto_pc(32'h20);
        step(0, 1, 0, 0, 1);
        check("stall_req_off", imem_req, 0);
        check("stall_frozen", IF_ID_Valid, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check("stall_req_off2", imem_req, 0);
        step(0, 0, 0, 0, 1);
        check("stall_rel_pc", IF_ID_PC, 32'h20);
        check("stall_rel_instr", IF_ID_Instruction, mem_word(32'h20));
        check("stall_next_addr", imem_addr, 32'h24);

        // Redirect while waiting at 0x40
        goto_pc(32'h40);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 0);
        check("drain_addr", imem_addr, 32'h40);
        check("drain_valid", IF_ID_Valid, 0);
        step(0, 0, 0, 0, 0);
        check("drain_addr2", imem_addr, 32'h40);
        step(0, 0, 0, 0, 1);
        check("drain_valid2", IF_ID_Valid, 0);
        check("post_drain_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1);
        check("redir_pc", IF_ID_PC, 32'h100);
        check("redir_valid", IF_ID_Valid, 1);

        // Redirect and Stall together at 0x80
        goto_pc(32'h80);
        step(0, 1, 1, 32'h200, 1);
        check("rs_valid", IF_ID_Valid, 0);
        step(0, 0, 0, 0, 1);
        check("rs_pc", IF_ID_PC, 32'h200);

        // JAL predecode at 0x30
        goto_pc(32'h30);
        step(0, 0, 0, 0, 1);
        check("jal_pc", IF_ID_PC, 32'h30);
`ifdef IF_PREDECODE_JAL_EN
        check("jal_next_addr", imem_addr, 32'h130);
        check("jal_pred", IF_ID_PredTaken, 1);
`else
        check("jal_next_addr", imem_addr, 32'h34);
        check("jal_pred", IF_ID_PredTaken, 0);
`endif

        // PC wrap at the top of the address space
        goto_pc(32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        check("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);
        check("wrap_pcp4", IF_ID_PCplus4, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);

        // Randomized traffic, including occasional reset mid-request
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom(),
                 $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
